// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared opcode constants, operation-class bit indices and decoded record type
// Feature macro: DECODE_ILLEGAL_TRAP_EN (consumed by decode_comb and decode_queue)
package decode_pkg;

   localparam int OPC_W     = 4;
   localparam int NUM_OPS   = 11;
   localparam int DEF_REG_W = 4;
   localparam int DEF_IMM_W = 2 * DEF_REG_W;

   localparam logic [OPC_W-1:0] OP_NOP   = 4'd0;
   localparam logic [OPC_W-1:0] OP_BR    = 4'd1;
   localparam logic [OPC_W-1:0] OP_CMP   = 4'd2;
   localparam logic [OPC_W-1:0] OP_ADD   = 4'd3;
   localparam logic [OPC_W-1:0] OP_SUB   = 4'd4;
   localparam logic [OPC_W-1:0] OP_MUL   = 4'd5;
   localparam logic [OPC_W-1:0] OP_DIV   = 4'd6;
   localparam logic [OPC_W-1:0] OP_LDR   = 4'd7;
   localparam logic [OPC_W-1:0] OP_STR   = 4'd8;
   localparam logic [OPC_W-1:0] OP_CONST = 4'd9;
   localparam logic [OPC_W-1:0] OP_HALT  = 4'd15;

   // Bit positions inside the one-hot dec_op vector
   typedef enum logic [3:0] {
      OPB_NOP, OPB_BR, OPB_CMP, OPB_ADD, OPB_SUB, OPB_MUL,
      OPB_DIV, OPB_LDR, OPB_STR, OPB_CONST, OPB_HALT
   } op_bit_e;

   // Decoded record at the default register width
   typedef struct packed {
      logic [OPC_W-1:0]     opcode;
      logic [DEF_REG_W-1:0] rd;
      logic [DEF_REG_W-1:0] rs;
      logic [DEF_REG_W-1:0] rt;
      logic [DEF_IMM_W-1:0] imm;
      logic [DEF_REG_W-1:0] cond;
      logic [NUM_OPS-1:0]   op;
   } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - pure combinational raw instruction to decoded fields
// Ports: instr (raw word) in; opcode/rd/rs/rt/imm/cond/op decoded fields out;
//        illegal_op out only when DECODE_ILLEGAL_TRAP_EN is defined.
module decode_comb import decode_pkg::*; #(
   parameter int  REG_W   = DEF_REG_W,
   localparam int IMM_W   = 2 * REG_W,
   localparam int INSTR_W = OPC_W + 3 * REG_W
) (
   input  logic [INSTR_W-1:0] instr,
   output logic [OPC_W-1:0]   opcode,
   output logic [REG_W-1:0]   rd,
   output logic [REG_W-1:0]   rs,
   output logic [REG_W-1:0]   rt,
   output logic [IMM_W-1:0]   imm,
   output logic [REG_W-1:0]   cond,
`ifdef DECODE_ILLEGAL_TRAP_EN
   output logic               illegal_op,
`endif
   output logic [NUM_OPS-1:0] op
);

   logic [REG_W-1:0] fa, fb, fc;

   assign opcode = instr[INSTR_W-1 -: OPC_W];
   assign fa     = instr[3*REG_W-1 : 2*REG_W];
   assign fb     = instr[2*REG_W-1 : REG_W];
   assign fc     = instr[REG_W-1 : 0];

   always_comb begin
      rd   = '0;
      rs   = '0;
      rt   = '0;
      imm  = '0;
      cond = '0;
      op   = '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_op = 1'b0;
`endif
      case (opcode)
         OP_NOP:   op[OPB_NOP] = 1'b1;
         OP_BR:    begin cond = fa; imm = {fb, fc}; op[OPB_BR] = 1'b1; end
         OP_CMP:   begin rs = fb; rt = fc; op[OPB_CMP] = 1'b1; end
         OP_ADD:   begin rd = fa; rs = fb; rt = fc; op[OPB_ADD] = 1'b1; end
         OP_SUB:   begin rd = fa; rs = fb; rt = fc; op[OPB_SUB] = 1'b1; end
         OP_MUL:   begin rd = fa; rs = fb; rt = fc; op[OPB_MUL] = 1'b1; end
         OP_DIV:   begin rd = fa; rs = fb; rt = fc; op[OPB_DIV] = 1'b1; end
         OP_LDR:   begin rd = fa; rs = fb; op[OPB_LDR] = 1'b1; end
         OP_STR:   begin rs = fb; rt = fc; op[OPB_STR] = 1'b1; end
         OP_CONST: begin rd = fa; imm = {fb, fc}; op[OPB_CONST] = 1'b1; end
         OP_HALT:  op[OPB_HALT] = 1'b1;
         default: begin
            // Opcodes 10-14 are unassigned: trap as HALT class or treat as NOP
`ifdef DECODE_ILLEGAL_TRAP_EN
            op[OPB_HALT] = 1'b1;
            illegal_op   = 1'b1;
`else
            op[OPB_NOP]  = 1'b1;
`endif
         end
      endcase
   end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - decoder with in-order FIFO of decoded records, halt latch, flush and optional illegal trap
// Ports: clk, reset_n (async active-low), flush (sync clear);
//        fetch side instr_valid/instr_ready/instr; scheduler side dec_valid/dec_ready and dec_* fields;
//        halted, count, and illegal (only when DECODE_ILLEGAL_TRAP_EN is defined).
module decode_queue import decode_pkg::*; #(
   parameter int  REG_W   = DEF_REG_W,
   parameter int  DEPTH   = 2,
   localparam int IMM_W   = 2 * REG_W,
   localparam int INSTR_W = OPC_W + 3 * REG_W,
   localparam int CNT_W   = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               flush,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [OPC_W-1:0]   dec_opcode,
   output logic [REG_W-1:0]   dec_rd,
   output logic [REG_W-1:0]   dec_rs,
   output logic [REG_W-1:0]   dec_rt,
   output logic [IMM_W-1:0]   dec_imm,
   output logic [REG_W-1:0]   dec_cond,
   output logic [NUM_OPS-1:0] dec_op,
   output logic               halted,
`ifdef DECODE_ILLEGAL_TRAP_EN
   output logic               illegal,
`endif
   output logic [CNT_W-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [OPC_W-1:0]   opcode;
      logic [REG_W-1:0]   rd;
      logic [REG_W-1:0]   rs;
      logic [REG_W-1:0]   rt;
      logic [IMM_W-1:0]   imm;
      logic [REG_W-1:0]   cond;
      logic [NUM_OPS-1:0] op;
   } rec_t;

   rec_t             rec_in, head;
   rec_t             mem_q [DEPTH];
   rec_t             mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             halted_q, halted_d;
   logic             full, push, pop;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic             in_illegal;
   logic             illegal_q, illegal_d;
`endif

   decode_comb #(.REG_W(REG_W)) u_decode (
      .instr      (instr),
      .opcode     (rec_in.opcode),
      .rd         (rec_in.rd),
      .rs         (rec_in.rs),
      .rt         (rec_in.rt),
      .imm        (rec_in.imm),
      .cond       (rec_in.cond),
`ifdef DECODE_ILLEGAL_TRAP_EN
      .illegal_op (in_illegal),
`endif
      .op         (rec_in.op)
   );

   // Gating with reset_n keeps instr_ready low for the whole reset interval
   assign full        = (count_q == CNT_W'(DEPTH));
   assign instr_ready = reset_n && !full && !halted_q && !flush;
   assign push        = instr_valid && instr_ready;
   assign dec_valid   = (count_q != '0);
   assign pop         = dec_valid && dec_ready && !flush;
   assign head        = mem_q[rd_ptr_q];
   assign halted      = halted_q;
   assign count       = count_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
   assign illegal     = illegal_q;
`endif

   // Head fields come straight from storage flops; forced to zero when empty
   always_comb begin
      dec_opcode = '0;
      dec_rd     = '0;
      dec_rs     = '0;
      dec_rt     = '0;
      dec_imm    = '0;
      dec_cond   = '0;
      dec_op     = '0;
      if (dec_valid) begin
         dec_opcode = head.opcode;
         dec_rd     = head.rd;
         dec_rs     = head.rs;
         dec_rt     = head.rt;
         dec_imm    = head.imm;
         dec_cond   = head.cond;
         dec_op     = head.op;
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      halted_d = halted_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_d = illegal_q;
`endif
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         halted_d = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
         illegal_d = 1'b0;
`endif
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = rec_in;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            if (rec_in.op[OPB_HALT]) halted_d = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
            if (in_illegal) illegal_d = 1'b1;
`endif
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         halted_q <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         halted_q <= halted_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - self-checking bench for decode_queue (honours DECODE_ILLEGAL_TRAP_EN)
module tb_decode_queue;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset_n, flush, instr_valid, dec_ready;
   logic [15:0] instr;
   logic        instr_ready, dec_valid, halted;
   logic [3:0]  dec_opcode, dec_rd, dec_rs, dec_rt, dec_cond;
   logic [7:0]  dec_imm;
   logic [10:0] dec_op;
   logic [1:0]  count;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  opcode, rd, rs, rt, cond;
      logic [7:0]  imm;
      logic [10:0] op;
   } exp_t;

   exp_t mq[$];
   bit   m_halted  = 1'b0;
   bit   m_illegal = 1'b0;

   decode_queue #(.REG_W(4), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (flush),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .dec_valid   (dec_valid),
      .dec_ready   (dec_ready),
      .dec_opcode  (dec_opcode),
      .dec_rd      (dec_rd),
      .dec_rs      (dec_rs),
      .dec_rt      (dec_rt),
      .dec_imm     (dec_imm),
      .dec_cond    (dec_cond),
      .dec_op      (dec_op),
      .halted      (halted),
`ifdef DECODE_ILLEGAL_TRAP_EN
      .illegal     (illegal),
`endif
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected record straight from the opcode table
   function automatic exp_t model_decode(input logic [15:0] w, output bit ill);
      exp_t e;
      logic [3:0] o, a, b, c;
      o = w[15:12]; a = w[11:8]; b = w[7:4]; c = w[3:0];
      e = '{opcode: o, rd: 4'h0, rs: 4'h0, rt: 4'h0, cond: 4'h0, imm: 8'h0, op: 11'h0};
      ill = 1'b0;
      if (o == 4'd1) begin e.cond = a; e.imm = {b, c}; end
      if (o == 4'd2 || o == 4'd8) begin e.rs = b; e.rt = c; end
      if (o >= 4'd3 && o <= 4'd6) begin e.rd = a; e.rs = b; e.rt = c; end
      if (o == 4'd7) begin e.rd = a; e.rs = b; end
      if (o == 4'd9) begin e.rd = a; e.imm = {b, c}; end
      if (o <= 4'd9)       e.op = 11'(1) << o;
      else if (o == 4'd15) e.op = 11'h400;
      else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
         e.op = 11'h400;
         ill  = 1'b1;
`else
         e.op = 11'h001;
`endif
      end
      return e;
   endfunction

   // Model update on each rising edge
   initial begin
      exp_t r;
      bit   ill, do_push, do_pop;
      forever begin
         @(posedge clk);
         if (!reset_n || flush) begin
            mq.delete();
            m_halted  = 1'b0;
            m_illegal = 1'b0;
         end else begin
            do_pop  = (mq.size() > 0) && dec_ready;
            do_push = instr_valid && (mq.size() < DEPTH) && !m_halted;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
               r = model_decode(instr, ill);
               mq.push_back(r);
               if (r.op[10]) m_halted = 1'b1;
               if (ill) m_illegal = 1'b1;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   initial begin
      exp_t h;
      bit   v;
      forever begin
         @(negedge clk);
         v = reset_n && (mq.size() > 0);
         h = '{opcode: 4'h0, rd: 4'h0, rs: 4'h0, rt: 4'h0, cond: 4'h0, imm: 8'h0, op: 11'h0};
         if (v) h = mq[0];
         chk("m_valid",  32'(dec_valid),  32'(v));
         chk("m_count",  32'(count),      reset_n ? 32'(mq.size()) : 32'd0);
         chk("m_halted", 32'(halted),     32'(reset_n && m_halted));
         chk("m_ready",  32'(instr_ready),
             32'(reset_n && mq.size() < DEPTH && !m_halted && !flush));
         chk("m_opcode", 32'(dec_opcode), 32'(h.opcode));
         chk("m_rd",     32'(dec_rd),     32'(h.rd));
         chk("m_rs",     32'(dec_rs),     32'(h.rs));
         chk("m_rt",     32'(dec_rt),     32'(h.rt));
         chk("m_imm",    32'(dec_imm),    32'(h.imm));
         chk("m_cond",   32'(dec_cond),   32'(h.cond));
         chk("m_op",     32'(dec_op),     32'(h.op));
`ifdef DECODE_ILLEGAL_TRAP_EN
         chk("m_illegal", 32'(illegal),   32'(reset_n && m_illegal));
`endif
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] w);
      instr_valid = 1'b1;
      instr       = w;
      tick();
      instr_valid = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; flush = 1'b0; instr_valid = 1'b0; dec_ready = 1'b0; instr = '0;
      tick();
      chk("rst_ready", 32'(instr_ready), 32'd0);
      chk("rst_valid", 32'(dec_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("rel_ready", 32'(instr_ready), 32'd1);

      // ADD appears one cycle after acceptance
      dec_ready = 1'b1;
      push(16'h3123);
      chk("add_valid", 32'(dec_valid), 32'd1);
      chk("add_rd", 32'(dec_rd), 32'd1);
      chk("add_rs", 32'(dec_rs), 32'd2);
      chk("add_rt", 32'(dec_rt), 32'd3);
      chk("add_op", 32'(dec_op), 32'h008);
      chk("add_count", 32'(count), 32'd1);
      tick();
      chk("add_drained", 32'(count), 32'd0);

      // BR then CONST, stalled consumer fills the queue
      dec_ready = 1'b0;
      push(16'h1A7F);
      push(16'h95AB);
      chk("br_count", 32'(count), 32'd2);
      chk("br_ready", 32'(instr_ready), 32'd0);
      chk("br_cond", 32'(dec_cond), 32'hA);
      chk("br_imm", 32'(dec_imm), 32'h7F);
      chk("br_op", 32'(dec_op), 32'h002);
      dec_ready = 1'b1;
      tick();
      chk("const_rd", 32'(dec_rd), 32'd5);
      chk("const_imm", 32'(dec_imm), 32'hAB);
      chk("const_op", 32'(dec_op), 32'h200);
      tick();
      chk("const_drained", 32'(count), 32'd0);

      // HALT closes intake; trailing ADD never accepted
      dec_ready = 1'b0;
      push(16'hF000);
      instr_valid = 1'b1; instr = 16'h3123;
      chk("halt_set", 32'(halted), 32'd1);
      chk("halt_ready", 32'(instr_ready), 32'd0);
      chk("halt_op", 32'(dec_op), 32'h400);
      tick();
      chk("halt_noacc", 32'(count), 32'd1);
      dec_ready = 1'b1;
      tick();
      tick();
      chk("halt_empty", 32'(count), 32'd0);
      chk("halt_sticky", 32'(halted), 32'd1);
      instr_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_unhalt", 32'(halted), 32'd0);

      // Full queue with push, pop and flush together
      dec_ready = 1'b0;
      push(16'h3123);
      push(16'h4123);
      chk("full_count", 32'(count), 32'd2);
      instr_valid = 1'b1; instr = 16'h5123; dec_ready = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0; instr_valid = 1'b0;
      chk("fl_count", 32'(count), 32'd0);
      chk("fl_valid", 32'(dec_valid), 32'd0);
      chk("fl_halted", 32'(halted), 32'd0);
      tick();
      chk("fl_nopush", 32'(count), 32'd0);

      // Undefined opcode 0xB
      dec_ready = 1'b0;
      push(16'hB000);
      chk("ill_opcode", 32'(dec_opcode), 32'hB);
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_halted", 32'(halted), 32'd1);
      chk("ill_op", 32'(dec_op), 32'h400);
`else
      chk("ill_halted", 32'(halted), 32'd0);
      chk("ill_op", 32'(dec_op), 32'h001);
`endif
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // Every opcode through the queue, flushed in between
      for (int i = 0; i < 16; i++) begin
         dec_ready = 1'b0;
         push({4'(i), 12'hA5C});
         dec_ready = 1'b1;
         tick();
         flush = 1'b1;
         tick();
         flush = 1'b0;
      end

      // Streaming push and pop together, pointers wrap
      dec_ready = 1'b1;
      instr_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         instr = {4'(3 + (i % 7)), 4'(i), 4'(15 - i), 4'(i + 2)};
         tick();
      end
      instr_valid = 1'b0;
      tick();
      tick();

      // Asynchronous reset while two entries are queued
      dec_ready = 1'b0;
      push(16'h7123);
      push(16'h8123);
      chk("ar_count", 32'(count), 32'd2);
      chk("ar_op", 32'(dec_op), 32'h080);
      #2 reset_n = 1'b0;
      #1;
      chk("ar_valid", 32'(dec_valid), 32'd0);
      chk("ar_cnt0", 32'(count), 32'd0);
      chk("ar_op0", 32'(dec_op), 32'd0);
      chk("ar_rd0", 32'(dec_rd), 32'd0);
      chk("ar_ready0", 32'(instr_ready), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("ar_ready1", 32'(instr_ready), 32'd1);
      chk("ar_cnt1", 32'(count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, parametrised successor to the combinational instruction decoder.
- Accepts raw instructions from the fetch unit over a valid/ready handshake, decodes them, and buffers the decoded records in a small FIFO.
- Presents records to the compute-core scheduler over a second valid/ready handshake.
- Adds a sticky halt latch, a flush, and a selectable illegal-opcode trap.

Parameters:
- REG_W, 4, register-index width; derived localparams: OPC_W=4, IMM_W=2*REG_W, INSTR_W=OPC_W+3*REG_W (16 at default).
- DEPTH, 2, FIFO entries; power of two, >=2.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous queue clear
- instr_valid  in  1  fetch presents instruction
- instr_ready  out  1  queue accepts instruction
- instr  in  INSTR_W  raw instruction
- dec_valid  out  1  head record valid
- dec_ready  in  1  consumer takes head
- dec_opcode  out  OPC_W  opcode field
- dec_rd  out  REG_W  destination register
- dec_rs  out  REG_W  source register 1
- dec_rt  out  REG_W  source register 2
- dec_imm  out  IMM_W  immediate value
- dec_cond  out  REG_W  branch condition (nzp)
- dec_op  out  11  one-hot operation class
- halted  out  1  HALT accepted, intake closed
- illegal  out  1  sticky illegal-opcode flag; exists only with the optional feature
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: all outputs 0; FIFO empty; halt latch and illegal latch cleared. instr_ready is 0 during reset and 1 after release.
- Field extraction: opcode=instr[INSTR_W-1 -: OPC_W]; A=[3R-1:2R]; B=[2R-1:R]; C=[R-1:0], where R=REG_W.
- Per-opcode decode; every field not listed is 0:
  - 0 NOP
  - 1 BR: cond=A, imm={B,C}
  - 2 CMP: rs=B, rt=C
  - 3-6 ADD/SUB/MUL/DIV: rd=A, rs=B, rt=C
  - 7 LDR: rd=A, rs=B
  - 8 STR: rs=B, rt=C
  - 9 CONST: rd=A, imm={B,C}
  - 15 HALT
  - 10-14: undefined opcodes (see Optional Feature)
- dec_op bit order: NOP0, BR1, CMP2, ADD3, SUB4, MUL5, DIV6, LDR7, STR8, CONST9, HALT10. Exactly one bit is set whenever dec_valid=1.
- instr_ready = !full && !halted && !flush.
  - A push occurs when instr_valid && instr_ready.
  - When full, no push occurs even if a pop happens in the same cycle (no bypass).
- Latency: an instruction accepted in cycle N appears at the head at N+1 if the queue was empty; the queue is strictly in order.
- Pop occurs when dec_valid && dec_ready. dec_* outputs are registered from the head entry and hold stable while dec_valid && !dec_ready.
- dec_valid=0 implies every dec_* field and dec_op read 0.
- Simultaneous push and pop when not full: count is unchanged; pointers wrap modulo DEPTH.
- HALT:
  - Accepting HALT sets halted at N+1 and the record is enqueued.
  - Entries already queued still drain.
  - While halted, instr_ready=0 regardless of instr_valid.
- flush:
  - In cycle N, flush empties the FIFO, clears halted, and clears illegal; dec_valid=0 at N+1.
  - flush has priority over push and pop in the same cycle; neither takes effect.
- Asynchronous reset mid-transfer discards all entries immediately; no partial state survives.
- count ranges 0..DEPTH, never exceeds DEPTH, and never underflows.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined:
  - Opcodes 10-14 decode as HALT class (dec_op bit10) with dec_opcode preserved and all other fields 0.
  - They set the sticky illegal output and the halted latch.
  - illegal is cleared by reset or flush.
- Undefined:
  - Opcodes 10-14 decode as NOP (dec_op bit0), with fields 0 and opcode preserved.
  - The illegal port is absent.

Decomposition:
- Package decode_pkg holds:
  - opcode constants OP_NOP..OP_HALT;
  - the dec_op bit-index enum;
  - the packed struct decoded_t {opcode, rd, rs, rt, imm, cond, op}, parametrised via REG_W-derived localparams.
- Sub-module decode_comb: the pure combinational instr -> decoded_t function.
- decode_queue wraps decode_comb with the FIFO, handshakes and latches.

Test Plan:
- After reset, push 0x3123 (ADD) with dec_ready=1 -> cycle+1: dec_valid=1, rd=1, rs=2, rt=3, dec_op=0x008, count=1.
- Push 0x1A7F (BR) and 0x95AB (CONST) with dec_ready=0 -> count=2, instr_ready=0; head cond=0xA, imm=0x7F; after one pop, head rd=5, imm=0xAB.
- Push 0xF000 followed by 0x3123 -> halted=1 next cycle, instr_ready=0, the ADD is never accepted; HALT drains with dec_op=0x400.
- Full queue with push, pop and flush asserted in the same cycle -> next cycle count=0, dec_valid=0, halted=0, no push taken.
- Push 0xB000:
  - with DECODE_ILLEGAL_TRAP_EN defined -> illegal=1, halted=1, dec_op=0x400, dec_opcode=0xB;
  - without the macro -> dec_op=0x001, halted=0.
- Assert reset_n=0 asynchronously while count=2 -> all outputs 0 immediately; after release, instr_ready=1 and count=0.
